osc_phase_acc: RTL and testbench
================================

OSC_PHASE_ACC -- requirements
Module: osc_phase_acc

Interface
REQ-001 Parameter VOICES, default 8, number of voices.
REQ-002 Parameter V_OSC, default 4, oscillators per voice.
REQ-003 Parameter V_WIDTH, default 3, voice index width.
REQ-004 Parameter O_WIDTH, default 2, oscillator index width.
REQ-005 clk  input  1  synthesis engine clock; all state on rising edge.
REQ-006 iRST_N  input  1  reset, asynchronous, active-low.
REQ-007 frame_start  input  1  one-cycle pulse marking the start of a sample frame.
REQ-008 slot_valid  input  1  osc_pitch_val and slot_idx valid this cycle.
REQ-009 slot_idx  input  V_WIDTH+O_WIDTH  {voice, osc} of the current increment.
REQ-010 osc_pitch_val  input  24  unsigned phase increment from pitch control.
REQ-011 note_on  input  1  one-cycle pulse: key start on voice note_voice.
REQ-012 note_voice  input  V_WIDTH  voice restarted by note_on.
REQ-013 sync_en  input  V_OSC  per-osc hard-sync enable; bit 0 ignored.
REQ-014 phase_out  output  16  accumulator bits [31:16] after update.
REQ-015 out_valid  output  1  phase_out/out_idx/wrap valid.
REQ-016 out_idx  output  V_WIDTH+O_WIDTH  slot of phase_out.
REQ-017 wrap  output  1  accumulator overflowed on this update.
REQ-018 frame_err  output  1  sticky: frame ended with slot count != VOICES*V_OSC.

Function
REQ-019 SHALL hold VOICES*V_OSC 32-bit accumulators, addressed by slot_idx.
REQ-020 Per valid slot: acc_next = acc + {osc_pitch_val, 8'h00}, modulo 2^32; wrap = carry out of bit 31.
REQ-021 Pipeline: cycle N slot_valid captured; cycle N+1 read/add; cycle N+2 out_valid=1 with results, accumulator written. Latency exactly 2 cycles, throughput 1 slot/cycle.
REQ-022 Back-to-back accesses to the same slot within 2 cycles SHALL use the forwarded, not stale, accumulator value.
REQ-023 Per-slot pending-restart bit: note_on sets pending for all V_OSC slots of note_voice.
REQ-024 Slot update with pending set: acc_next = {osc_pitch_val, 8'h00}, wrap=0, pending cleared.
REQ-025 note_on in the same cycle a slot of note_voice is captured: that slot restarts this update and its pending ends cleared; other slots of the voice are set pending.
REQ-026 Per-voice sync flag: set when osc 0 of that voice updates with wrap=1; cleared on frame_start.
REQ-027 Slot with osc index k>0, sync_en[k]=1 and the voice's sync flag set: restart as in REQ-024 (pending also cleared).
REQ-028 Sync applies only to oscillators processed after osc 0 within the same frame; osc slots SHALL be presented in ascending osc order per voice.
REQ-029 Frame slot counter counts slot_valid cycles; frame_start checks count (ignored before first frame_start after reset), sets frame_err if count != VOICES*V_OSC, then counter restarts from the frame_start cycle (slot_valid coinciding with frame_start counts in the new frame).
REQ-030 frame_err clears only on reset.
REQ-031 slot_valid=0: no accumulator change, out_valid deasserts 2 cycles later.
REQ-032 Out-of-range slot_idx (voice >= VOICES or osc >= V_OSC): update discarded, out_valid still asserted, phase_out=0, wrap=0.

Reset
REQ-033 iRST_N low SHALL immediately clear all accumulators, pending bits, sync flags, slot counter, pipeline registers and frame_err; phase_out=0, out_valid=0, out_idx=0, wrap=0.
REQ-034 Reset mid-frame SHALL discard in-flight pipeline contents; no writes occur after reset release from pre-reset slots.
REQ-035 After release, first frame_start SHALL not set frame_err.

Verification
REQ-036 Reset, slot 0 increment 24'h000100 for 3 frames -> phase_out 16'h0001, 16'h0002, 16'h0003, each 2 cycles after slot_valid.
REQ-037 Slot 5 acc=32'hFFFF_0000, increment 24'h000200 -> acc 32'h0001_0000, phase_out 16'h0001, wrap=1.
REQ-038 note_on voice 2 mid-frame, increment 24'h001000 -> next update of slots {2,0..3} phase_out 16'h0010, wrap=0; voice 1 slots unaffected.
REQ-039 sync_en=4'b0010, voice 0 osc 0 wraps -> osc 1 of voice 0 restarts same frame; osc 2 continues accumulating.
REQ-040 31 slots then frame_start -> frame_err=1 and stays 1 through later correct 32-slot frames until reset.
REQ-041 Same slot on consecutive cycles, increment 24'h000100, acc 0 -> phase_out 16'h0001 then 16'h0002 (forwarding).

Source files
------------

// File: rtl/osc_phase_acc.sv
`default_nettype none
// ============================================================================
// Module   : osc_phase_acc
// Purpose  : Time-multiplexed 32-bit phase accumulators for VOICES x V_OSC
//            oscillator slots. One slot is updated per cycle with a 2-cycle
//            capture -> read/add -> write/output pipeline. Supports per-voice
//            key restart (note_on), per-oscillator hard sync to osc 0 of the
//            same voice, and a sticky frame slot-count error flag.
// Ports    : clk, iRST_N (async, active-low)
//            frame_start        - start-of-frame pulse
//            slot_valid/slot_idx/osc_pitch_val - slot increment input
//            note_on/note_voice - restart all oscillators of a voice
//            sync_en            - per-osc hard-sync enable (bit 0 unused)
//            phase_out/out_valid/out_idx/wrap - per-slot update result
//            frame_err          - sticky frame slot-count error
// Revision : 1.0 - initial release
// ============================================================================
module osc_phase_acc #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       iRST_N,
  input  logic                       frame_start,
  input  logic                       slot_valid,
  input  logic [V_WIDTH+O_WIDTH-1:0] slot_idx,
  input  logic [23:0]                osc_pitch_val,
  input  logic                       note_on,
  input  logic [V_WIDTH-1:0]         note_voice,
  input  logic [V_OSC-1:0]           sync_en,
  output logic [15:0]                phase_out,
  output logic                       out_valid,
  output logic [V_WIDTH+O_WIDTH-1:0] out_idx,
  output logic                       wrap,
  output logic                       frame_err
);

  localparam int c_SLOTS = VOICES * V_OSC;
  localparam int c_AW    = (c_SLOTS > 1) ? $clog2(c_SLOTS) : 1;
  localparam int c_IW    = V_WIDTH + O_WIDTH;
  // one spare bit so a saturated count can never alias the expected count
  localparam int c_CW    = $clog2(c_SLOTS + 1) + 1;

  function automatic logic [c_AW-1:0] f_addr(input int v, input int o);
    return c_AW'(v * V_OSC + o);
  endfunction

  // ---------------------------------------------------------------- state
  logic [31:0]         r_acc [c_SLOTS];
  logic [c_SLOTS-1:0]  r_pend;
  logic [VOICES-1:0]   r_sync;

  // capture stage
  logic                r_s1_valid;
  logic [c_IW-1:0]     r_s1_idx;
  logic [23:0]         r_s1_inc;
  logic                r_s1_note;
  logic                r_s1_sync_en;

  // frame accounting
  logic [c_CW-1:0]     r_slot_cnt;
  logic                r_frame_seen;

  // ---------------------------------------------------------------- capture
  logic [V_WIDTH-1:0]  w_cap_voice;
  logic [O_WIDTH-1:0]  w_cap_osc;
  logic                w_cap_sync_en;

  assign w_cap_voice = slot_idx[c_IW-1:O_WIDTH];
  assign w_cap_osc   = slot_idx[O_WIDTH-1:0];

  always_comb begin
    w_cap_sync_en = 1'b0;
    for (int k = 0; k < V_OSC; k++) begin
      if (int'(w_cap_osc) == k) w_cap_sync_en = sync_en[k];
    end
  end

  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s1_valid   <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_inc     <= '0;
      r_s1_note    <= 1'b0;
      r_s1_sync_en <= 1'b0;
    end else begin
      r_s1_valid   <= slot_valid;
      r_s1_idx     <= slot_idx;
      r_s1_inc     <= osc_pitch_val;
      // a note_on landing with one of its own slots restarts that slot now
      r_s1_note    <= slot_valid && note_on && (note_voice == w_cap_voice);
      r_s1_sync_en <= w_cap_sync_en;
    end
  end

  // ---------------------------------------------------------------- read/add
  // The accumulator array is written at the end of this stage, so a slot
  // re-entering the stage on the very next cycle already reads fresh data.
  logic [V_WIDTH-1:0]  w_s1_voice;
  logic [O_WIDTH-1:0]  w_s1_osc;
  logic                w_s1_in_range;
  logic [c_AW-1:0]     w_s1_addr;
  logic                w_s1_restart;
  logic [31:0]         w_s1_inc_ext;
  logic [32:0]         w_s1_sum;
  logic [31:0]         w_s1_next;
  logic                w_s1_wrap;
  logic                w_s1_write;

  assign w_s1_voice   = r_s1_idx[c_IW-1:O_WIDTH];
  assign w_s1_osc     = r_s1_idx[O_WIDTH-1:0];
  assign w_s1_inc_ext = {r_s1_inc, 8'h00};

  always_comb begin
    w_s1_in_range = (int'(w_s1_voice) < VOICES) && (int'(w_s1_osc) < V_OSC);
    w_s1_addr     = w_s1_in_range ? f_addr(int'(w_s1_voice), int'(w_s1_osc)) : '0;
    w_s1_restart  = 1'b0;
    if (w_s1_in_range) begin
      w_s1_restart = r_s1_note || r_pend[w_s1_addr] ||
                     ((w_s1_osc != '0) && r_s1_sync_en && r_sync[w_s1_voice]);
    end
    w_s1_sum   = {1'b0, r_acc[w_s1_addr]} + {1'b0, w_s1_inc_ext};
    w_s1_next  = w_s1_restart ? w_s1_inc_ext : w_s1_sum[31:0];
    w_s1_wrap  = w_s1_restart ? 1'b0 : w_s1_sum[32];
    w_s1_write = r_s1_valid && w_s1_in_range;
  end

  // ---------------------------------------------------------------- write
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < c_SLOTS; i++) r_acc[i] <= '0;
    end else if (w_s1_write) begin
      r_acc[w_s1_addr] <= w_s1_next;
    end
  end

  // Clear by the retiring slot first, then set by note_on, so a note_on that
  // arrives after a slot was read still leaves that slot pending.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_pend <= '0;
    end else begin
      if (w_s1_write) r_pend[w_s1_addr] <= 1'b0;
      if (note_on && (int'(note_voice) < VOICES)) begin
        for (int o = 0; o < V_OSC; o++) begin
          if (!(slot_valid && (w_cap_voice == note_voice) && (int'(w_cap_osc) == o)))
            r_pend[f_addr(int'(note_voice), o)] <= 1'b1;
        end
      end
    end
  end

  // frame_start wins: an osc 0 update retiring in that cycle belongs to the
  // frame that is ending.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync <= '0;
    end else if (frame_start) begin
      r_sync <= '0;
    end else if (w_s1_write && (w_s1_osc == '0) && w_s1_wrap) begin
      r_sync[w_s1_voice] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      phase_out <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      wrap      <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_idx   <= r_s1_idx;
        phase_out <= w_s1_in_range ? w_s1_next[31:16] : 16'h0000;
        wrap      <= w_s1_in_range && w_s1_wrap;
      end
    end
  end

  // ---------------------------------------------------------------- frame check
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_slot_cnt   <= '0;
      r_frame_seen <= 1'b0;
      frame_err    <= 1'b0;
    end else if (frame_start) begin
      if (r_frame_seen && (r_slot_cnt != c_CW'(c_SLOTS))) frame_err <= 1'b1;
      r_frame_seen <= 1'b1;
      r_slot_cnt   <= slot_valid ? c_CW'(1) : '0;
    end else if (slot_valid && (r_slot_cnt != '1)) begin
      r_slot_cnt <= r_slot_cnt + c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_osc_phase_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_phase_acc
// Purpose  : Directed + randomised bench for osc_phase_acc (default params).
//            Each driven slot pushes its expected result, tagged with the
//            cycle it is due, onto a scoreboard queue; a negedge monitor pops
//            and compares, and checks out_valid stays low on idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_phase_acc;

  logic        clk = 1'b0;
  logic        iRST_N;
  logic        frame_start;
  logic        slot_valid;
  logic [4:0]  slot_idx;
  logic [23:0] osc_pitch_val;
  logic        note_on;
  logic [2:0]  note_voice;
  logic [3:0]  sync_en;
  logic [15:0] phase_out;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        wrap;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [4:0]  idx;
    logic [15:0] ph;
    logic        wr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_acc [32];
  logic [31:0] m_pend;
  logic [7:0]  m_sync;

  osc_phase_acc dut (
    .clk          (clk),
    .iRST_N       (iRST_N),
    .frame_start  (frame_start),
    .slot_valid   (slot_valid),
    .slot_idx     (slot_idx),
    .osc_pitch_val(osc_pitch_val),
    .note_on      (note_on),
    .note_voice   (note_voice),
    .sync_en      (sync_en),
    .phase_out    (phase_out),
    .out_valid    (out_valid),
    .out_idx      (out_idx),
    .wrap         (wrap),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (iRST_N === 1'b1) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_idx",   32'(out_idx),   32'(mon_e.idx));
        chk("phase_out", 32'(phase_out), 32'(mon_e.ph));
        chk("wrap",      32'(wrap),      32'(mon_e.wr));
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
      end
    end
  end

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_acc[i] = '0;
    m_pend = '0;
    m_sync = '0;
    sb.delete();
  endtask

  // Drive one cycle and advance the reference model in program order.
  task automatic step(input logic fs, input logic sv, input logic [4:0] idx,
                      input logic [23:0] inc, input logic non, input logic [2:0] nv,
                      input logic use_exp, input logic [15:0] xph, input logic xwr);
    logic [2:0]  v;
    logic [1:0]  o;
    logic        rs;
    logic [32:0] sum;
    logic [31:0] nx;
    logic        wr;
    exp_t        e;
    frame_start   = fs;
    slot_valid    = sv;
    slot_idx      = idx;
    osc_pitch_val = inc;
    note_on       = non;
    note_voice    = nv;
    v = idx[4:2];
    o = idx[1:0];
    if (fs) m_sync = '0;
    if (sv) begin
      rs  = m_pend[idx] | (non && nv == v) | ((o != 2'd0) && sync_en[o] && m_sync[v]);
      sum = {1'b0, m_acc[idx]} + {1'b0, inc, 8'h00};
      if (rs) begin
        nx = {inc, 8'h00};
        wr = 1'b0;
      end else begin
        nx = sum[31:0];
        wr = sum[32];
      end
      m_acc[idx]  = nx;
      m_pend[idx] = 1'b0;
      if (o == 2'd0 && wr) m_sync[v] = 1'b1;
      e.due = cyc + 2;
      e.idx = idx;
      e.ph  = use_exp ? xph : nx[31:16];
      e.wr  = use_exp ? xwr : wr;
      sb.push_back(e);
    end
    if (non) begin
      for (int k = 0; k < 4; k++)
        if (!(sv && idx == {nv, 2'(k)})) m_pend[{nv, 2'(k)}] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [4:0] idx, input logic [23:0] inc);
    step(1'b0, 1'b1, idx, inc, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic slotx(input logic [4:0] idx, input logic [23:0] inc,
                       input logic [15:0] xph, input logic xwr);
    step(1'b0, 1'b1, idx, inc, 1'b0, 3'd0, 1'b1, xph, xwr);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 24'd0, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    iRST_N = 1'b0; frame_start = 1'b0; slot_valid = 1'b0; slot_idx = '0;
    osc_pitch_val = '0; note_on = 1'b0; note_voice = '0; sync_en = '0;
    m_reset();
    #1;
    chk("rst_phase_out", 32'(phase_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    chk("rst_wrap",      32'(wrap),      32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 iRST_N = 1'b1;
    idle(); idle();

    // three full frames, slot 0 stepping by 0x100 per frame
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 32; s++)
        step(s == 0, 1'b1, 5'(s), (s == 0) ? 24'h000100 : 24'h0, 1'b0, 3'd0,
             s == 0, 16'(f + 1), 1'b0);
    chk("frame_err_good", 32'(frame_err), 32'd0);

    // short frame (31 slots) then sticky error through correct frames
    for (int s = 0; s < 31; s++)
      step(s == 0, 1'b1, 5'(s), 24'($urandom), 1'b0, 3'd0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 24'($urandom), 1'b0, 3'd0, 1'b0, 16'h0, 1'b0);
    chk("frame_err_short", 32'(frame_err), 32'd1);
    for (int s = 1; s < 32; s++) slot(5'(s), 24'($urandom));
    step(1'b1, 1'b1, 5'd0, 24'h0, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0);
    chk("frame_err_sticky", 32'(frame_err), 32'd1);

    // reset mid-frame with slots in flight
    slot(5'd0, 24'h000100);
    slot(5'd1, 24'h000100);
    #2;
    m_reset();
    iRST_N = 1'b0;
    slot_valid = 1'b0; frame_start = 1'b0; note_on = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_phase_out", 32'(phase_out), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 iRST_N = 1'b1;
    idle(); idle(); idle();
    slotx(5'd0, 24'h000100, 16'h0001, 1'b0);

    // back-to-back and 2-apart accesses to the same slot
    slotx(5'd3, 24'h000100, 16'h0001, 1'b0);
    slotx(5'd3, 24'h000100, 16'h0002, 1'b0);
    slot(5'd7, 24'h000300);
    slot(5'd3, 24'h000100);

    // overflow with wrap
    slotx(5'd5, 24'hFFFF00, 16'hFFFF, 1'b0);
    slotx(5'd5, 24'h000200, 16'h0001, 1'b1);

    // note_on restart of voice 2, voice 1 unaffected
    for (int s = 4; s < 12; s++) slot(5'(s), 24'h001000);
    step(1'b0, 1'b0, 5'd0, 24'h0, 1'b1, 3'd2, 1'b0, 16'h0, 1'b0);
    for (int s = 8; s < 12; s++) slotx(5'(s), 24'h001000, 16'h0010, 1'b0);
    for (int s = 4; s < 8; s++) slot(5'(s), 24'h001000);
    // note_on coinciding with capture of a slot of that voice
    step(1'b0, 1'b1, 5'd8, 24'h002000, 1'b1, 3'd2, 1'b1, 16'h0020, 1'b0);
    slotx(5'd8,  24'h002000, 16'h0040, 1'b0);
    slotx(5'd9,  24'h002000, 16'h0020, 1'b0);
    slotx(5'd10, 24'h002000, 16'h0020, 1'b0);

    // hard sync: first frame_start after reset must not flag an error
    sync_en = 4'b0010;
    step(1'b1, 1'b0, 5'd0, 24'h0, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0);
    chk("frame_err_first", 32'(frame_err), 32'd0);
    slotx(5'd1, 24'h001000, 16'h0010, 1'b0);
    slotx(5'd2, 24'h001000, 16'h0010, 1'b0);
    slotx(5'd0, 24'hFFFF00, 16'h0000, 1'b1);
    slotx(5'd1, 24'h001000, 16'h0010, 1'b0);
    slotx(5'd2, 24'h001000, 16'h0020, 1'b0);
    slotx(5'd1, 24'h001000, 16'h0010, 1'b0);
    repeat (26) slot(5'd31, 24'h0);
    // exactly 32 slots; slot with frame_start counts in the new frame and
    // sees the sync flag already cleared
    step(1'b1, 1'b1, 5'd1, 24'h001000, 1'b0, 3'd0, 1'b1, 16'h0020, 1'b0);
    chk("frame_err_exact", 32'(frame_err), 32'd0);

    // randomised traffic against the model
    for (int i = 0; i < 80; i++) begin
      sync_en = 4'($urandom_range(0, 15));
      step(1'b0, $urandom_range(0, 3) != 0, 5'($urandom), 24'($urandom),
           $urandom_range(0, 7) == 0, 3'($urandom), 1'b0, 16'h0, 1'b0);
    end
    repeat (4) idle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
